// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   state_t      : FSM state encoding (also exported on state_o for debug)
//   OP_*         : instruction opcodes recognised in DECODE
//   ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU encodings
//   ctl_t        : registered Moore strobe bundle, ctl_for() maps a state to it
package cpu_ctl_pkg;

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        MEM_WB,
        EXEC_R,
        R_WB,
        EXEC_I,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // 'fetch' marks the FETCH state; irWrite and the fetch-time pcWrite are
    // qualified by mem_ready in the same cycle outside the register.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctl_t;

    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR, EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            I_WB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            HALT: begin
                c.halted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and the datapath.
//   master : controller side (consumes opcode/zero/ready, drives ctl_* and state_o)
//   slave  : datapath side
// With ILLEGAL_TRAP_EN defined the bundle also carries ctl_illegal.
interface multicycle_control_if;

    logic [5:0] instr_opcode;
    logic       alu_zero;
    logic       mem_ready;

    logic       ctl_pcWrite;
    logic       ctl_pcWriteCond;
    logic [1:0] ctl_pcSource;
    logic       ctl_iorD;
    logic       ctl_memRead;
    logic       ctl_memWrite;
    logic       ctl_irWrite;
    logic       ctl_regDst;
    logic       ctl_memToReg;
    logic       ctl_regWrite;
    logic       ctl_aluSrcA;
    logic [1:0] ctl_aluSrcB;
    logic [1:0] ctl_aluOp;
    logic       ctl_halted;
    logic       ctl_memErr;
    logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
    logic       ctl_illegal;
`endif

    modport master (
        input  instr_opcode, alu_zero, mem_ready,
        output ctl_pcWrite, ctl_pcWriteCond, ctl_pcSource, ctl_iorD,
               ctl_memRead, ctl_memWrite, ctl_irWrite, ctl_regDst,
               ctl_memToReg, ctl_regWrite, ctl_aluSrcA, ctl_aluSrcB,
               ctl_aluOp, ctl_halted, ctl_memErr, state_o
`ifdef ILLEGAL_TRAP_EN
        , output ctl_illegal
`endif
    );

    modport slave (
        output instr_opcode, alu_zero, mem_ready,
        input  ctl_pcWrite, ctl_pcWriteCond, ctl_pcSource, ctl_iorD,
               ctl_memRead, ctl_memWrite, ctl_irWrite, ctl_regDst,
               ctl_memToReg, ctl_regWrite, ctl_aluSrcA, ctl_aluSrcB,
               ctl_aluOp, ctl_halted, ctl_memErr, state_o
`ifdef ILLEGAL_TRAP_EN
        , input ctl_illegal
`endif
    );

endinterface

// File: rtl/multicycle_control_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting for mem_ready in a memory state.
//   clk, rst_n : clock, async active-low reset
//   in_wait    : controller is in FETCH, MEM_RD or MEM_WR
//   mem_ready  : memory handshake
//   timeout    : combinational; this is the WAIT_LIMIT-th cycle without ready
// The counter is held at zero outside wait states and cleared whenever
// mem_ready arrives (the controller always leaves the state then), which is
// the same as clearing it on entry to each wait state.
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);

    // Counter only has to reach WAIT_LIMIT-1; with no limit it simply wraps.
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!in_wait || mem_ready) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    always_comb begin
        timeout = 1'b0;
        if ((WAIT_LIMIT > 0) && in_wait && !mem_ready &&
            ((32'(count) + 32'd1) == 32'(WAIT_LIMIT))) begin
            timeout = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the shared-ALU/shared-memory MIPS
// datapath. Strobes are registered from the state; the only exception is
// irWrite and the FETCH pcWrite, which complete on mem_ready in-cycle.
//   clk    : clock, rising edge
//   rst_n  : async active-low reset; all strobes drop immediately
//   bus    : multicycle_control_if.master (opcode, zero, mem_ready, ctl_*)
// Parameters: HALT_OPCODE (opcode entering HALT), WAIT_LIMIT (0 = unbounded).
// Macro ILLEGAL_TRAP_EN: unknown opcodes halt and set sticky ctl_illegal.
module multicycle_control
    import cpu_ctl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F,
    parameter int         WAIT_LIMIT  = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    state_t state;
    ctl_t   ctl;
    logic   mem_err;
    logic   in_wait;
    logic   timeout;
`ifdef ILLEGAL_TRAP_EN
    logic   illegal;
`endif

    assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_wait   (in_wait),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    // Each transition loads the strobes belonging to the destination state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            ctl     <= '0;
            mem_err <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal <= 1'b0;
`endif
        end else begin
            case (state)
                RESET: begin
                    state <= FETCH;  ctl <= ctl_for(FETCH);
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        state <= DECODE; ctl <= ctl_for(DECODE);
                    end else if (timeout) begin
                        state <= HALT;   ctl <= ctl_for(HALT);
                        mem_err <= 1'b1;
                    end
                end
                DECODE: begin
                    if (bus.instr_opcode == HALT_OPCODE) begin
                        state <= HALT; ctl <= ctl_for(HALT);
                    end else begin
                        case (bus.instr_opcode)
                            OP_RTYPE: begin
                                state <= EXEC_R;   ctl <= ctl_for(EXEC_R);
                            end
                            OP_ADDI, OP_ADDIU: begin
                                state <= EXEC_I;   ctl <= ctl_for(EXEC_I);
                            end
                            OP_LW, OP_SW: begin
                                state <= MEM_ADDR; ctl <= ctl_for(MEM_ADDR);
                            end
                            OP_BEQ: begin
                                state <= BRANCH;   ctl <= ctl_for(BRANCH);
                            end
                            OP_J: begin
                                state <= JUMP;     ctl <= ctl_for(JUMP);
                            end
                            default: begin
`ifdef ILLEGAL_TRAP_EN
                                state   <= HALT;   ctl <= ctl_for(HALT);
                                illegal <= 1'b1;
`else
                                state <= FETCH;    ctl <= ctl_for(FETCH);
`endif
                            end
                        endcase
                    end
                end
                MEM_ADDR: begin
                    if (bus.instr_opcode == OP_LW) begin
                        state <= MEM_RD; ctl <= ctl_for(MEM_RD);
                    end else begin
                        state <= MEM_WR; ctl <= ctl_for(MEM_WR);
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ready) begin
                        state <= MEM_WB; ctl <= ctl_for(MEM_WB);
                    end else if (timeout) begin
                        state <= HALT;   ctl <= ctl_for(HALT);
                        mem_err <= 1'b1;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ready) begin
                        state <= FETCH;  ctl <= ctl_for(FETCH);
                    end else if (timeout) begin
                        state <= HALT;   ctl <= ctl_for(HALT);
                        mem_err <= 1'b1;
                    end
                end
                EXEC_R: begin
                    state <= R_WB;  ctl <= ctl_for(R_WB);
                end
                EXEC_I: begin
                    state <= I_WB;  ctl <= ctl_for(I_WB);
                end
                MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
                    state <= FETCH; ctl <= ctl_for(FETCH);
                end
                HALT: ;
                default: begin
                    state <= RESET; ctl <= '0;
                end
            endcase
        end
    end

    assign bus.ctl_pcWrite     = ctl.pc_write | (ctl.fetch & bus.mem_ready);
    assign bus.ctl_irWrite     = ctl.fetch & bus.mem_ready;
    assign bus.ctl_pcWriteCond = ctl.pc_write_cond;
    assign bus.ctl_pcSource    = ctl.pc_source;
    assign bus.ctl_iorD        = ctl.iord;
    assign bus.ctl_memRead     = ctl.mem_read;
    assign bus.ctl_memWrite    = ctl.mem_write;
    assign bus.ctl_regDst      = ctl.reg_dst;
    assign bus.ctl_memToReg    = ctl.mem_to_reg;
    assign bus.ctl_regWrite    = ctl.reg_write;
    assign bus.ctl_aluSrcA     = ctl.alu_src_a;
    assign bus.ctl_aluSrcB     = ctl.alu_src_b;
    assign bus.ctl_aluOp       = ctl.alu_op;
    assign bus.ctl_halted      = ctl.halted;
    assign bus.ctl_memErr      = mem_err;
    assign bus.state_o         = state;
`ifdef ILLEGAL_TRAP_EN
    assign bus.ctl_illegal     = illegal;
`endif

endmodule
